param_stack: RTL and testbench

PARAM_STACK -- requirements
Module: param_stack

---
 rtl/stack_pkg.sv | 22 ++
 rtl/stack_mem.sv | 27 ++
 rtl/param_stack.sv | 152 +++++++++++++++
 tb/tb_param_stack.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the parameterised LIFO stack: default sizes,
// occupancy-counter width and the per-edge operation codes.
package stack_pkg;

   localparam int DATA_W_DEF = 4;
   localparam int DEPTH_DEF  = 8;

   // Width needed to hold every occupancy value 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Operation selected on an edge; REPLACE is simultaneous push and pop.
   typedef enum logic [2:0] {
      IDLE,
      PUSH,
      POP,
      REPLACE,
      CLEAR
   } op_e;

endpackage

// File: rtl/stack_mem.sv
// Stack storage: DEPTH x DATA_W array, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module stack_mem #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 8,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Single write port; the caller guarantees waddr_i < DEPTH when we_i is high.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_stack.sv
// Parameterised LIFO stack with registered pop data, a combinational top
// peek, occupancy flags and one-cycle overflow/underflow pulses.
module param_stack
   import stack_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic [DATA_W-1:0]         Data_In,
   input  logic                      Push,
   input  logic                      Pop,
   input  logic                      Clear,
   output logic [DATA_W-1:0]         Data_Out,
   output logic                      Pop_Valid,
   output logic [DATA_W-1:0]         Top,
   output logic [cnt_w(DEPTH)-1:0]   Count,
   output logic                      Full,
   output logic                      Empty,
   output logic                      Overflow,
   output logic                      Underflow
);

   localparam int CNT_W = cnt_w(DEPTH);
   localparam int AW    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              pop_valid_q, pop_valid_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   op_e               op;
   logic              empty, full;
   logic [CNT_W-1:0]  top_idx;
   logic              we, mem_we;
   logic [AW-1:0]     waddr, raddr;
   logic [DATA_W-1:0] rdata;

   // Flags come from the registered count only, never from the request inputs.
   assign empty   = (count_q == '0);
   assign full    = (count_q == DEPTH_C);
   assign top_idx = count_q - ONE_C;
   // Read address parked at 0 when empty so it never points outside the array.
   assign raddr   = empty ? '0 : AW'(top_idx);
   // A write on the same edge as a reset is discarded along with the op.
   assign mem_we  = we & ~Rst;

   stack_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk_i   (Clk),
      .we_i    (mem_we),
      .waddr_i (waddr),
      .wdata_i (Data_In),
      .raddr_i (raddr),
      .rdata_o (rdata)
   );

   // Decode request lines by priority: clear, replace, push, pop, idle.
   always_comb begin
      op = IDLE;
      if (Clear) begin
         op = CLEAR;
      end else if (Push && Pop) begin
         op = REPLACE;
      end else if (Push) begin
         op = PUSH;
      end else if (Pop) begin
         op = POP;
      end
   end

   // Next-state for count, pop data, pulses and the storage write port.
   always_comb begin
      count_d     = count_q;
      dout_d      = dout_q;
      pop_valid_d = 1'b0;
      ovf_d       = 1'b0;
      unf_d       = 1'b0;
      we          = 1'b0;
      waddr       = AW'(count_q);
      unique case (op)
         CLEAR: begin
            count_d = '0;
         end
         REPLACE: begin
            pop_valid_d = 1'b1;
            if (empty) begin
               // Nothing stored: the pushed word passes straight through.
               dout_d = Data_In;
            end else begin
               dout_d = rdata;
               we     = 1'b1;
               waddr  = AW'(top_idx);
            end
         end
         PUSH: begin
            if (full) begin
               ovf_d = 1'b1;
            end else begin
               we      = 1'b1;
               waddr   = AW'(count_q);
               count_d = count_q + ONE_C;
            end
         end
         POP: begin
            if (empty) begin
               unf_d = 1'b1;
            end else begin
               dout_d      = rdata;
               count_d     = top_idx;
               pop_valid_d = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // Control and output registers; reset takes effect immediately.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         count_q     <= '0;
         dout_q      <= '0;
         pop_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         count_q     <= count_d;
         dout_q      <= dout_d;
         pop_valid_q <= pop_valid_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
      end
   end

   assign Data_Out  = dout_q;
   assign Pop_Valid = pop_valid_q;
   assign Count     = count_q;
   assign Full      = full;
   assign Empty     = empty;
   assign Overflow  = ovf_q;
   assign Underflow = unf_q;
   assign Top       = empty ? '0 : rdata;

endmodule

// File: tb/tb_param_stack.sv
// Scoreboard bench for param_stack (DATA_W=4, DEPTH=8): stimulus queues the
// expected pulse/data, a monitor pops and compares on every output pulse.
module tb_param_stack;

   logic       Clk;
   logic       Rst;
   logic [3:0] Data_In;
   logic       Push;
   logic       Pop;
   logic       Clear;
   logic [3:0] Data_Out;
   logic       Pop_Valid;
   logic [3:0] Top;
   logic [3:0] Count;
   logic       Full;
   logic       Empty;
   logic       Overflow;
   logic       Underflow;

   typedef struct {
      logic [2:0] flags;   // {Pop_Valid, Overflow, Underflow}
      int         data;
      string      nm;
   } exp_t;

   exp_t sbq[$];
   int   compared   = 0;
   int   mismatched = 0;

   param_stack #(
      .DATA_W (4),
      .DEPTH  (8)
   ) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .Data_In   (Data_In),
      .Push      (Push),
      .Pop       (Pop),
      .Clear     (Clear),
      .Data_Out  (Data_Out),
      .Pop_Valid (Pop_Valid),
      .Top       (Top),
      .Count     (Count),
      .Full      (Full),
      .Empty     (Empty),
      .Overflow  (Overflow),
      .Underflow (Underflow)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic exp_pv(input int d, input string nm);
      exp_t e;
      e.flags = 3'b100; e.data = d; e.nm = nm;
      sbq.push_back(e);
   endtask

   task automatic exp_flag(input logic [2:0] f, input string nm);
      exp_t e;
      e.flags = f; e.data = 0; e.nm = nm;
      sbq.push_back(e);
   endtask

   // One request over one active edge; returns 1 time unit after the edge.
   task automatic step(input bit pu, input bit po, input bit cl, input int d);
      Push    = pu;
      Pop     = po;
      Clear   = cl;
      Data_In = d[3:0];
      @(posedge Clk);
      #1;
      Push  = 1'b0;
      Pop   = 1'b0;
      Clear = 1'b0;
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge Clk);
         if (!Rst && (Pop_Valid || Overflow || Underflow)) begin
            if (sbq.size() == 0) begin
               chk("unexpected_pulse", int'({Pop_Valid, Overflow, Underflow}), 0);
            end else begin
               e = sbq.pop_front();
               chk({e.nm, "_flags"}, int'({Pop_Valid, Overflow, Underflow}), int'(e.flags));
               if (e.flags == 3'b100) begin
                  chk({e.nm, "_data"}, int'(Data_Out), e.data);
               end
            end
         end
      end
   endtask

   initial begin
      Rst = 1'b1; Push = 1'b0; Pop = 1'b0; Clear = 1'b0; Data_In = '0;
      fork
         monitor();
      join_none

      // Reset state
      #3;
      chk("rst_count", int'(Count), 0);
      chk("rst_empty", int'(Empty), 1);
      chk("rst_full", int'(Full), 0);
      chk("rst_dout", int'(Data_Out), 0);
      chk("rst_top", int'(Top), 0);
      chk("rst_pulses", int'({Pop_Valid, Overflow, Underflow}), 0);
      @(negedge Clk);
      Rst = 1'b0;

      // Fill to full, then one rejected push
      for (int i = 1; i <= 8; i++) begin
         step(1, 0, 0, i);
         chk("fill_count", int'(Count), i);
         chk("fill_top", int'(Top), i);
      end
      chk("full_flag", int'(Full), 1);
      chk("full_empty", int'(Empty), 0);
      exp_flag(3'b010, "overflow");
      step(1, 0, 0, 9);
      chk("ovf_count", int'(Count), 8);
      chk("ovf_top", int'(Top), 8);

      // Drain in LIFO order, then one rejected pop
      for (int i = 8; i >= 1; i--) begin
         exp_pv(i, "drain");
         step(0, 1, 0, 0);
         chk("drain_count", int'(Count), i - 1);
      end
      chk("drain_empty", int'(Empty), 1);
      chk("drain_top", int'(Top), 0);
      exp_flag(3'b001, "underflow");
      step(0, 1, 0, 0);
      chk("unf_dout", int'(Data_Out), 1);
      chk("unf_count", int'(Count), 0);

      // Replace top with Count=3, top=5
      step(1, 0, 0, 3);
      step(1, 0, 0, 4);
      step(1, 0, 0, 5);
      exp_pv(5, "replace");
      step(1, 1, 0, 10);
      chk("replace_top", int'(Top), 10);
      chk("replace_count", int'(Count), 3);
      exp_pv(10, "pop_after_replace");
      step(0, 1, 0, 0);
      exp_pv(4, "pop_4");
      step(0, 1, 0, 0);
      exp_pv(3, "pop_3");
      step(0, 1, 0, 0);
      chk("replace_drained", int'(Empty), 1);

      // Push&Pop while empty passes the word through
      exp_pv(12, "passthru");
      step(1, 1, 0, 12);
      chk("passthru_count", int'(Count), 0);
      chk("passthru_empty", int'(Empty), 1);

      // Clear wins over a simultaneous push, Data_Out untouched
      for (int i = 1; i <= 4; i++) step(1, 0, 0, i);
      chk("preclear_count", int'(Count), 4);
      step(1, 0, 1, 7);
      chk("clear_count", int'(Count), 0);
      chk("clear_empty", int'(Empty), 1);
      chk("clear_dout", int'(Data_Out), 12);
      chk("clear_top", int'(Top), 0);

      // Asynchronous reset between edges, with a push held across a reset edge
      for (int i = 1; i <= 5; i++) step(1, 0, 0, i);
      chk("prerst_count", int'(Count), 5);
      #2;
      Rst = 1'b1;
      #1;
      chk("arst_count", int'(Count), 0);
      chk("arst_empty", int'(Empty), 1);
      chk("arst_full", int'(Full), 0);
      chk("arst_dout", int'(Data_Out), 0);
      chk("arst_top", int'(Top), 0);
      Push = 1'b1; Data_In = 4'd6;
      @(posedge Clk);
      #1;
      Push = 1'b0;
      chk("rst_edge_push_dropped", int'(Count), 0);
      #2;
      Rst = 1'b0;
      step(1, 0, 0, 9);
      chk("post_rst_count", int'(Count), 1);
      chk("post_rst_top", int'(Top), 9);

      // Replace while full: no overflow, top swapped
      for (int i = 2; i <= 8; i++) step(1, 0, 0, i);
      chk("refill_full", int'(Full), 1);
      exp_pv(8, "replace_full");
      step(1, 1, 0, 15);
      chk("replace_full_count", int'(Count), 8);
      chk("replace_full_top", int'(Top), 15);
      exp_pv(15, "pop_replaced");
      step(0, 1, 0, 0);
      chk("final_count", int'(Count), 7);
      chk("final_top", int'(Top), 7);

      repeat (3) @(negedge Clk);
      #1;
      chk("scoreboard_drained", sbq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
